pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush steering for load-use, branch, mul/div and memory waits.
// Latency: stall/flush outputs are combinational from state and inputs; counters and flags update on the next edge.
// Backpressure: memory-not-ready and outstanding mul/div hold the front of the pipe; nothing upstream is dropped.
module pipeline_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs_D,
  input  logic [4:0]       Rt_D,
  input  logic [4:0]       Rt_E,
  input  logic             MemRead_E,
  input  logic             BranchTaken_E,
  input  logic             MulDivStart_E,
  input  logic             MulDivDone,
  input  logic             MemReq_M,
  input  logic             MemReady,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_M,
  output logic             Flush_W,
  output logic [CNT_W-1:0] StallCount,
  output logic             MdTimeout
);

  // Timeout counter only needs to hold 0 .. MD_TIMEOUT-1.
  localparam int TO_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MDWAIT  = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mdto_q, mdto_d;

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic lu;

  // Load in E whose destination feeds a decode source; r0 never creates a dependency.
  assign lu = MemRead_E && (Rt_E != 5'd0) && ((Rt_E == Rs_D) || (Rt_E == Rt_D));

  // Next-state and raw stall/flush decode; priority in RUN is memory wait, branch, mul/div, load-use.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    mdto_d  = mdto_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    case (state_q)
      RUN: begin
        if (MemReq_M && !MemReady) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
          state_d = MEMWAIT;
        end else if (BranchTaken_E) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (MulDivStart_E) begin
          to_d    = '0;
          state_d = MDWAIT;
        end else if (lu) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MDWAIT: begin
        // M holds a bubble here, so the memory handshake is not looked at.
        if (MulDivDone) begin
          state_d = RUN;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          to_d    = to_q + 1'b1;
          if (to_q == TO_LAST) begin
            mdto_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      MEMWAIT: begin
        // E is frozen, so branch/mul-div requests are seen again once back in RUN.
        if (MemReady) begin
          state_d = RUN;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced quiet while reset is held, regardless of what the inputs request.
  assign Stall_F = reset & stall_f;
  assign Stall_D = reset & stall_d;
  assign Stall_E = reset & stall_e;
  assign Stall_M = reset & stall_m;
  assign Flush_D = reset & flush_d;
  assign Flush_E = reset & flush_e;
  assign Flush_M = reset & flush_m;
  assign Flush_W = reset & flush_w;

  // Saturating stall-cycle counter keyed off the fetch stall.
  always_comb begin
    cnt_d = cnt_q;
    if (Stall_F && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, timeout counter, stall counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      to_q    <= '0;
      cnt_q   <= '0;
      mdto_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      mdto_q  <= mdto_d;
    end
  end

  assign StallCount = cnt_q;
  assign MdTimeout  = mdto_q;

endmodule
